// File: rtl/uart_xmit_ctl.sv
// -----------------------------------------------------------------------------
// uart_xmit_ctl
//
// Control and baud-timing stage for a UART transmit shift register. Bytes
// arrive over a ready/valid handshake. The data byte is wired straight to the
// shift register's data input and is captured on the same edge as sh_ld. This
// block only sequences the shift register so that one 8N1 frame (start, eight
// data bits LSB first, stop) appears on txd for each accepted byte.
//
// Parameters:
//   CLKFREQ  system clock frequency in Hz
//   BAUD     line rate in bits/s
//   (BAUD_COUNT = CLKFREQ/BAUD clocks per bit; must be at least 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-high reset
//   valid    in   upstream byte available
//   ready    out  controller can accept a byte this cycle
//   sh_idle  out  shift register: force the line to mark (has priority)
//   sh_ld    out  shift register: load {stop, data, start}
//   sh_en    out  shift register: shift one bit toward txd
//   tx_done  out  one-cycle pulse as the final stop-bit period ends
//
// Build option:
//   UART_XMIT_CTL_TWO_STOP_EN  when defined, a second stop bit is sent
//                              (frame = 11 bit periods instead of 10).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_xmit_ctl #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic ready,
  output logic sh_idle,
  output logic sh_ld,
  output logic sh_en,
  output logic tx_done
);

  localparam int BAUD_COUNT = CLKFREQ / BAUD;
  localparam int BCW        = (BAUD_COUNT < 2) ? 1 : $clog2(BAUD_COUNT);

  generate
    if (BAUD_COUNT < 2) begin : g_bad_baud
      $error("uart_xmit_ctl: CLKFREQ/BAUD must be at least 2");
    end
  endgenerate

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Index of the final bit period of a frame (start bit is index 0).
`ifdef UART_XMIT_CTL_TWO_STOP_EN
  localparam logic [3:0] BIT_LAST = 4'd10;
`else
  localparam logic [3:0] BIT_LAST = 4'd9;
`endif

  localparam logic [BCW-1:0] CNT_LAST = BCW'(BAUD_COUNT - 1);
  // The final stop-bit period ends one count early inside SEND: the IDLE
  // cycle that follows supplies its last clock. That IDLE cycle is where a
  // new byte can be loaded, so back-to-back frames are exactly
  // BAUD_COUNT*(BIT_LAST+1) cycles apart with no extra mark time.
  localparam logic [BCW-1:0] CNT_END  = BCW'(BAUD_COUNT - 2);

  logic [0:0]     state;
  logic [BCW-1:0] baud_cnt;
  logic [3:0]     bit_cnt;
  logic           done_pend;

  logic in_idle;
  logic bit_end;
  logic frame_end;

  always_comb begin
    in_idle   = (state == IDLE);
    bit_end   = (state == SEND) && (baud_cnt == CNT_LAST) && (bit_cnt != BIT_LAST);
    frame_end = (state == SEND) && (baud_cnt == CNT_END)  && (bit_cnt == BIT_LAST);
  end

  // All strobes are held low while rst is asserted; the shift register's own
  // reset governs the line during that time.
  always_comb begin
    ready   = ~rst & in_idle;
    sh_ld   = ~rst & in_idle & valid;
    sh_idle = ~rst & in_idle & ~valid;
    sh_en   = ~rst & bit_end;
    tx_done = ~rst & done_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      done_pend <= 1'b0;
    end else begin
      // tx_done lands in the IDLE cycle that closes the last stop bit.
      done_pend <= frame_end;
      case (state)
        IDLE: begin
          if (valid) begin
            state    <= SEND;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SEND: begin
          if (frame_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
